trig_sched: RTL and testbench
=============================

TRIG_SCHED -- requirements
Module: trig_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of DAC channels served.
REQ-002 SHALL have parameter CNT_W, default 32, width of shot and period counters.
REQ-003 SHALL have parameter OFS_W, default 16, width of each per-channel offset.
REQ-004 SHALL have ports:
  clk  in  1  single clock, 250 MHz RFSoC fabric clock.
  rst  in  1  asynchronous, active-high reset.
  start  in  1  single-cycle request to begin a run.
  abort  in  1  terminate the run immediately.
  shot_count  in  CNT_W  number of shots per run.
  period  in  CNT_W  cycles per shot.
  ch_enable  in  NUM_CH  per-channel trigger enable.
  ch_offset  in  NUM_CH*OFS_W  per-channel trigger offset within a shot; channel i uses bits [i*OFS_W +: OFS_W].
  trig_width  in  8  trigger pulse length in cycles.
  trigger_out  out  NUM_CH  per-channel trigger to dac_ctrl trigger_in, registered.
  busy  out  1  high whenever state is not IDLE.
  done  out  1  one-cycle pulse at normal run completion.
  shot_idx  out  CNT_W  current shot number, 0-based.
REQ-005 SHALL use one clock, clk, and an asynchronous active-high reset, rst.

Function
REQ-006 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-007 SHALL, in IDLE, accept start only when shot_count!=0 and period!=0; otherwise start SHALL be ignored and the block SHALL stay in IDLE.
REQ-008 SHALL, on an accepted start at edge T, latch shot_count, period, ch_enable, ch_offset and trig_width, clear period_cnt and shot_idx, and enter RUN at T+1; later input changes SHALL NOT affect the run.
REQ-009 SHALL, in RUN, increment period_cnt each cycle, wrapping from period-1 to 0; on wrap, shot_idx SHALL increment.
REQ-010 SHALL fire channel i in the RUN cycle where period_cnt==ch_offset[i] and ch_enable[i]==1; trigger_out[i] SHALL go high on the next edge (offset 0 -> high at T+2).
REQ-011 SHALL hold a fired trigger high for max(trig_width,1) cycles using a per-channel down-counter.
REQ-012 SHALL reload the width counter, not extend past it, when a channel re-fires while its pulse is still active; the pulse SHALL stay high with no gap.
REQ-013 SHALL never fire a channel whose offset is >= period.
REQ-014 SHALL, when period_cnt==period-1 and shot_idx==shot_count-1, go to DRAIN on the next edge; no further fires SHALL occur.
REQ-015 SHALL stay in DRAIN until all trigger_out are 0, then go to DONE.
REQ-016 SHALL, in DONE, assert done for exactly one cycle and return to IDLE on the next edge.
REQ-017 SHALL, on abort in any non-IDLE state, force trigger_out to 0 and enter IDLE on the next edge with no done pulse; abort SHALL have priority over every other transition.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL hold shot_idx at its final value after a run until the next accepted start.
REQ-020 SHALL use CNT_W-bit unsigned compares with no overflow; shot_count = 2^CNT_W-1 SHALL be legal.

Reset
REQ-021 SHALL, on rst assertion at any time, immediately set state=IDLE, trigger_out=0, busy=0, done=0, shot_idx=0, and clear all counters.
REQ-022 SHALL, on rst deassertion, stay in IDLE until a valid start is accepted.

Verification
REQ-023 Normal run: shot_count=3, period=10, ch_enable=0x03, offsets ch0=0 and ch1=4, trig_width=2, start at T -> ch0 high at T+2..T+3, T+12..T+13 and T+22..T+23; ch1 high at T+6..T+7 and the matching later windows; done pulses once at T+33.
REQ-024 Offset out of range: period=5 with ch2 offset=5 enabled -> ch2 never fires; other channels are unaffected.
REQ-025 Re-fire overlap: period=3, offset=0, trig_width=5 -> trigger_out stays continuously high; DRAIN holds until the pulse expires; then done fires.
REQ-026 Abort: abort during shot 1 with triggers active -> all trigger_out=0 and busy=0 on the next edge; no done pulse; a subsequent start runs normally.
REQ-027 Invalid start: shot_count=0 or period=0 -> busy stays 0 and no triggers fire.
REQ-028 Async reset mid-run: rst pulses between edges -> outputs clear immediately without a clock edge.

Source files
------------

// File: rtl/trig_sched.sv
// trig_sched: shot-based multi-channel trigger scheduler.
// Runs shot_count shots of period cycles and fires enabled channels at their per-shot offsets.
module trig_sched #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32,
    parameter int OFS_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CNT_W-1:0]          shot_count,
    input  logic [CNT_W-1:0]          period,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH*OFS_W-1:0]   ch_offset,
    input  logic [7:0]                trig_width,
    output logic [NUM_CH-1:0]         trigger_out,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          shot_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int MW = (CNT_W > OFS_W) ? CNT_W : OFS_W;
    localparam logic [CNT_W-1:0] ONE = 1;

    state_t state_q, state_d;
    logic [CNT_W-1:0] shots_q, shots_d, period_q, period_d, pcnt_q, pcnt_d, idx_q, idx_d;
    logic [NUM_CH-1:0] en_q, en_d, trig_q, trig_d, match, fire;
    logic [NUM_CH*OFS_W-1:0] ofs_q, ofs_d;
    logic [7:0] width_q, width_d;
    logic [NUM_CH-1:0][7:0] wcnt_q, wcnt_d;
    logic done_q, done_d, wrap, last;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            match[i] = MW'(pcnt_q) == MW'(ofs_q[i*OFS_W +: OFS_W]);
    end

    always_comb begin
        state_d  = state_q;
        shots_d  = shots_q;
        period_d = period_q;
        pcnt_d   = pcnt_q;
        idx_d    = idx_q;
        en_d     = en_q;
        ofs_d    = ofs_q;
        width_d  = width_q;
        done_d   = 1'b0;
        fire     = '0;
        wrap     = pcnt_q == period_q - ONE;
        last     = wrap && idx_q == shots_q - ONE;
        case (state_q)
            IDLE: if (start && shot_count != '0 && period != '0) begin
                shots_d  = shot_count;
                period_d = period;
                en_d     = ch_enable;
                ofs_d    = ch_offset;
                width_d  = trig_width;
                pcnt_d   = '0;
                idx_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                pcnt_d  = wrap ? '0 : pcnt_q + ONE;
                idx_d   = (wrap && !last) ? idx_q + ONE : idx_q;
                state_d = last ? DRAIN : RUN;
                fire    = en_q & match;
            end
            DRAIN: state_d = (trig_q == '0) ? DONE : DRAIN;
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        endcase
        // A re-fire reloads the full width, so overlapping pulses merge without a gap.
        for (int i = 0; i < NUM_CH; i++) begin
            wcnt_d[i] = fire[i] ? ((width_q == 8'd0) ? 8'd1 : width_q) :
                        (wcnt_q[i] == 8'd0) ? 8'd0 : wcnt_q[i] - 8'd1;
            trig_d[i] = fire[i] || wcnt_q[i] > 8'd1;
        end
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            trig_d  = '0;
            wcnt_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shots_q  <= '0;
            period_q <= '0;
            pcnt_q   <= '0;
            idx_q    <= '0;
            en_q     <= '0;
            ofs_q    <= '0;
            width_q  <= '0;
            wcnt_q   <= '0;
            trig_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shots_q  <= shots_d;
            period_q <= period_d;
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            en_q     <= en_d;
            ofs_q    <= ofs_d;
            width_q  <= width_d;
            wcnt_q   <= wcnt_d;
            trig_q   <= trig_d;
            done_q   <= done_d;
        end
    end

    assign trigger_out = trig_q;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign shot_idx    = idx_q;
endmodule

// File: tb/tb_trig_sched.sv
// tb_trig_sched: scoreboard bench for trig_sched.
// Expected {done,busy,trigger_out} per cycle comes from a shot/offset window model.
module tb_trig_sched;
    localparam int NC = 8, CW = 32, OW = 16;
    logic clk = 1'b0, rst, start, abort;
    logic [CW-1:0] shot_count, period, shot_idx;
    logic [NC-1:0] ch_enable, trigger_out;
    logic [NC*OW-1:0] ch_offset;
    logic [7:0] trig_width;
    logic busy, done;
    int vecs = 0, errs = 0;
    logic [NC+1:0] sb[$];
    logic [NC+1:0] e;
    int ms, mp, mw, n;
    logic [NC-1:0] men;
    int mo[NC];

    trig_sched #(.NUM_CH(NC), .CNT_W(CW), .OFS_W(OW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .shot_count(shot_count), .period(period), .ch_enable(ch_enable),
        .ch_offset(ch_offset), .trig_width(trig_width),
        .trigger_out(trigger_out), .busy(busy), .done(done), .shot_idx(shot_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [NC-1:0] mtrig(int k);
        logic [NC-1:0] r = '0;
        for (int i = 0; i < NC; i++)
            if (men[i] && mo[i] < mp)
                for (int s = 0; s < ms; s++)
                    if (k >= 2 + s*mp + mo[i] && k < 2 + s*mp + mo[i] + mw) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int push_run();
        int t = 1 + ms*mp;
        while (mtrig(t) != '0) t++;
        for (int k = 1; k <= t + 3; k++)
            sb.push_back({k == t + 2, k <= t + 1, mtrig(k)});
        return t + 3;
    endfunction

    task automatic set_cfg(input int s, input int p, input logic [NC-1:0] en, input int w);
        ms = s; mp = p; men = en; mw = (w == 0) ? 1 : w;
        shot_count = s; period = p; ch_enable = en; trig_width = w[7:0];
        for (int i = 0; i < NC; i++) ch_offset[i*OW +: OW] = OW'(mo[i]);
    endtask

    task automatic go();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        mo = '{default: 0};
        set_cfg(0, 0, '0, 0);
        #12;
        vecs++;
        if ({done, busy, trigger_out, shot_idx} !== '0) begin
            errs++; $display("FAIL reset: got %h exp 0", {done, busy, trigger_out, shot_idx});
        end
        @(negedge clk) rst = 1'b0;
        repeat (3) begin
            @(negedge clk); vecs++;
            if ({done, busy, trigger_out} !== '0) begin
                errs++; $display("FAIL reset_idle: got %b exp 0", {done, busy, trigger_out});
            end
        end
    endtask

    task automatic test_normal();
        mo = '{default: 0}; mo[1] = 4;
        set_cfg(3, 10, 8'h03, 2);
        n = push_run();
        go();
        shot_count = 1; period = 7; ch_enable = '1; ch_offset = '0; trig_width = 9;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk); e = sb.pop_front(); vecs++;
            if ({done, busy, trigger_out} !== e) begin
                errs++; $display("FAIL normal k=%0d: got %b exp %b", k, {done, busy, trigger_out}, e);
            end
            start = (k == 5);
        end
        vecs++;
        if (shot_idx !== 2) begin
            errs++; $display("FAIL normal_shot_idx: got %0d exp 2", shot_idx);
        end
    endtask

    task automatic test_offset_range();
        mo = '{default: 0}; mo[0] = 1; mo[2] = 5; mo[3] = 4;
        set_cfg(2, 5, 8'b0000_1101, 0);
        n = push_run();
        go();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk); e = sb.pop_front(); vecs++;
            if ({done, busy, trigger_out} !== e) begin
                errs++; $display("FAIL offset_range k=%0d: got %b exp %b", k, {done, busy, trigger_out}, e);
            end
        end
    endtask

    task automatic test_refire();
        mo = '{default: 0};
        set_cfg(3, 3, 8'h01, 5);
        n = push_run();
        go();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk); e = sb.pop_front(); vecs++;
            if ({done, busy, trigger_out} !== e) begin
                errs++; $display("FAIL refire k=%0d: got %b exp %b", k, {done, busy, trigger_out}, e);
            end
        end
    endtask

    task automatic test_abort();
        mo = '{default: 0};
        set_cfg(3, 10, 8'h01, 4);
        n = push_run();
        go();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk); e = sb.pop_front(); vecs++;
            if ({done, busy, trigger_out} !== e) begin
                errs++; $display("FAIL abort_pre k=%0d: got %b exp %b", k, {done, busy, trigger_out}, e);
            end
        end
        sb.delete();
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        repeat (6) begin
            vecs++;
            if ({done, busy, trigger_out} !== '0) begin
                errs++; $display("FAIL abort_post: got %b exp 0", {done, busy, trigger_out});
            end
            @(negedge clk);
        end
        mo = '{default: 0}; mo[5] = 2;
        set_cfg(1, 4, 8'h20, 1);
        n = push_run();
        go();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk); e = sb.pop_front(); vecs++;
            if ({done, busy, trigger_out} !== e) begin
                errs++; $display("FAIL abort_rerun k=%0d: got %b exp %b", k, {done, busy, trigger_out}, e);
            end
        end
    endtask

    task automatic test_invalid();
        mo = '{default: 0};
        for (int j = 0; j < 2; j++) begin
            set_cfg(j == 0 ? 0 : 4, j == 0 ? 10 : 0, 8'hFF, 3);
            go();
            repeat (12) begin
                @(negedge clk); vecs++;
                if ({done, busy, trigger_out} !== '0) begin
                    errs++; $display("FAIL invalid_%0d: got %b exp 0", j, {done, busy, trigger_out});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        mo = '{default: 0}; mo[1] = 4;
        set_cfg(3, 10, 8'h03, 2);
        go();
        repeat (12) @(negedge clk);
        vecs++;
        if ({busy, trigger_out, shot_idx} !== {1'b1, 8'h01, 32'd1}) begin
            errs++; $display("FAIL async_pre: got %h exp %h", {busy, trigger_out, shot_idx}, {1'b1, 8'h01, 32'd1});
        end
        #1 rst = 1'b1;
        #1;
        vecs++;
        if ({done, busy, trigger_out, shot_idx} !== '0) begin
            errs++; $display("FAIL async_reset: got %h exp 0", {done, busy, trigger_out, shot_idx});
        end
        @(negedge clk) rst = 1'b0;
        repeat (4) begin
            @(negedge clk); vecs++;
            if ({done, busy, trigger_out} !== '0) begin
                errs++; $display("FAIL async_idle: got %b exp 0", {done, busy, trigger_out});
            end
        end
    endtask

    task automatic test_max_shots();
        mo = '{default: 0};
        set_cfg(1, 2, 8'h01, 1);
        shot_count = '1;
        go();
        repeat (7) @(negedge clk);
        vecs++;
        if ({busy, shot_idx} !== {1'b1, 32'd3}) begin
            errs++; $display("FAIL max_shots: got busy=%b idx=%0d exp busy=1 idx=3", busy, shot_idx);
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        vecs++;
        if ({done, busy, trigger_out} !== '0) begin
            errs++; $display("FAIL max_shots_abort: got %b exp 0", {done, busy, trigger_out});
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_offset_range();
        test_refire();
        test_abort();
        test_invalid();
        test_async_reset();
        test_max_shots();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
